code_packer: RTL and testbench

- Downstream consumer of the Huffman-code core's serial output (`out_valid` / `out_code` / `out_mode` after the output pads).
- Packs the variable-length serial code bitstream of each frame into 8-bit words, MSB-first.
- Tags each word with frame-end and valid-bit-count information.
- Buffers the words in a small FIFO behind a valid/ready handshake, because the serial source cannot be stalled.

---
 rtl/code_packer.sv | 91 +++++++++
 tb/tb_code_packer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/code_packer.sv
// code_packer: packs a serial, frame-delimited code bitstream into MSB-first 8-bit words queued in a valid/ready FIFO
// clk, rst        : clock, synchronous active-high reset
// in_valid        : serial bit valid; one contiguous high run is one frame
// in_code         : serial code bit
// in_mode         : frame mode tag, sampled on the first bit of a frame
// pk_ready        : consumer accepts the head word
// pk_valid        : head word available
// pk_data         : packed word, first bit in bit 7, partial words zero-padded
// pk_nbits        : number of valid bits in pk_data (1..8)
// pk_last         : last word of the frame
// pk_mode         : mode tag of the word's frame
// ovf             : sticky, a word was dropped because the FIFO was full
module code_packer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_code,
  input  logic       in_mode,
  input  logic       pk_ready,
  output logic       pk_valid,
  output logic [7:0] pk_data,
  output logic [3:0] pk_nbits,
  output logic       pk_last,
  output logic       pk_mode,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;
  state_t        r_state;
  logic [7:0]    r_sr, r_hold, r_tail;
  logic [2:0]    r_cnt, r_tail_n;
  logic          r_hold_v, r_mode, r_tail_mode, r_ovf;
  logic [13:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          w_end, w_push, w_pop, w_acc;
  logic [7:0]    w_part;
  logic [13:0]   w_word, w_head;
  assign w_end  = r_state == RECV && !in_valid;
  assign w_part = r_sr << (3'd0 - r_cnt);
  assign w_push = r_state == FLUSH || w_end || (in_valid && r_hold_v);
  assign w_word = r_state == FLUSH ? {r_tail_mode, 1'b1, 1'b0, r_tail_n, r_tail} :
                  (w_end && r_cnt != 3'd0 && !r_hold_v) ? {r_mode, 1'b1, 1'b0, r_cnt, w_part} :
                  {r_mode, w_end && r_cnt == 3'd0, 4'd8, r_hold};
  assign pk_valid = r_count != '0;
  assign w_pop    = pk_valid && pk_ready;
  assign w_acc    = w_push && (r_count != (AW+1)'(DEPTH) || w_pop);
  assign w_head   = pk_valid ? r_mem[r_rp] : '0;
  assign {pk_mode, pk_last, pk_nbits, pk_data} = w_head;
  assign ovf      = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_tail      <= '0;
      r_tail_n    <= '0;
      r_tail_mode <= 1'b0;
      r_mode      <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state  <= in_valid ? RECV : (w_end && r_cnt != 3'd0 && r_hold_v) ? FLUSH : IDLE;
      r_hold_v <= in_valid && r_cnt == 3'd7;
      if (in_valid) begin
        r_sr  <= {r_sr[6:0], in_code};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) r_hold <= {r_sr[6:0], in_code};
        if (r_state != RECV) r_mode <= in_mode;
      end else if (w_end) begin
        r_cnt       <= '0;
        r_tail      <= w_part;
        r_tail_n    <= r_cnt;
        r_tail_mode <= r_mode;
      end
      if (w_acc) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_acc) - (AW+1)'(w_pop);
      if (w_push && !w_acc) r_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_acc) r_mem[r_wp] <= w_word;
  end
endmodule

// File: tb/tb_code_packer.sv
// tb_code_packer: randomized and directed check of code_packer against a frame-chunking reference model
module tb_code_packer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, in_code = 0, in_mode = 0, pk_ready = 0;
  logic pk_valid, pk_last, pk_mode, ovf;
  logic [7:0] pk_data;
  logic [3:0] pk_nbits;
  logic [13:0] exp_q[$], got_q[$];
  int n_checks = 0, n_fail = 0, held = 0;
  bit rnd = 0, exp_ovf = 0;

  code_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_mode(in_mode),
    .pk_ready(pk_ready), .pk_valid(pk_valid), .pk_data(pk_data), .pk_nbits(pk_nbits),
    .pk_last(pk_last), .pk_mode(pk_mode), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && pk_valid && pk_ready) got_q.push_back({pk_mode, pk_last, pk_nbits, pk_data});

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) pk_ready = !pk_ready ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // Reference: a frame of n bits is cut into 8-bit chunks, first bit in bit 7,
  // the final chunk left-aligned and flagged last. With limited set, the consumer
  // is stalled so only DEPTH words fit and the rest are dropped.
  function automatic void model_frame(input logic [31:0] bits, input int n, input logic mode, input bit limited);
    int k;
    logic [7:0] d;
    for (int s = 0; s < n; s += 8) begin
      k = (n - s < 8) ? n - s : 8;
      d = '0;
      for (int j = 0; j < k; j++) d[7-j] = bits[n-1-s-j];
      if (limited && held == DEPTH) exp_ovf = 1;
      else begin
        exp_q.push_back({mode, 1'(s + 8 >= n), 4'(k), d});
        if (limited) held++;
      end
    end
  endfunction

  task automatic send_frame(input logic [31:0] bits, input int n, input logic mode, input bit limited);
    model_frame(bits, n, mode, limited);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_code = bits[n-1-i];
      in_mode = mode;
      step();
    end
    in_valid = 0;
    in_code = 0;
    in_mode = 0;
  endtask

  task automatic drain(input string tag);
    int t;
    rnd = 0;
    pk_ready = 1;
    t = 0;
    while ((pk_valid || t < 2) && t < 200) begin
      step();
      t++;
    end
    check({tag, "_drain_timeout"}, 32'(t < 200), 32'd1);
    check({tag, "_words"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i][7:0], exp_q[i][7:0]);
      check($sformatf("%s_nbits%0d", tag, i), got_q[i][11:8], exp_q[i][11:8]);
      check($sformatf("%s_last%0d", tag, i), got_q[i][12], exp_q[i][12]);
      check($sformatf("%s_mode%0d", tag, i), got_q[i][13], exp_q[i][13]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, pk_valid, 0);
    check({tag, "_data"}, pk_data, 0);
    check({tag, "_nbits"}, pk_nbits, 0);
    check({tag, "_last"}, pk_last, 0);
    check({tag, "_mode"}, pk_mode, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    step();
    step();
    check_zero("reset");
    rst = 0;
    pk_ready = 1;
    step();

    send_frame(32'hB2, 8, 0, 0);
    step();
    drain("byte_b2");

    send_frame(32'b10110010101, 11, 0, 0);
    step();
    drain("bits11");

    send_frame(32'h1, 1, 1, 0);
    step();
    send_frame(32'hFF, 8, 0, 0);
    step();
    drain("one_then_ff");

    pk_ready = 0;
    held = 0;
    exp_ovf = 0;
    for (int f = 1; f <= 5; f++) begin
      send_frame(32'(f), 8, 0, 1);
      step();
      check($sformatf("stall_valid_f%0d", f), pk_valid, 1);
      check($sformatf("stall_head_f%0d", f), pk_data, 8'h01);
      check($sformatf("stall_ovf_f%0d", f), ovf, exp_ovf);
    end
    drain("stall_drain");
    check("ovf_sticky", ovf, 1);

    rst = 1;
    step();
    rst = 0;
    check("ovf_cleared", ovf, 0);
    pk_ready = 0;
    for (int f = 0; f < 4; f++) begin
      send_frame(32'h11 + 32'(f), 8, 0, 0);
      step();
    end
    send_frame(32'h15, 8, 1, 0);
    pk_ready = 1;
    step();
    check("full_pop_push_ovf", ovf, 0);
    check("full_pop_push_valid", pk_valid, 1);
    drain("full_pop_push");

    pk_ready = 0;
    send_frame(32'h33, 8, 1, 0);
    step();
    check("pre_rst_data", pk_data, 8'h33);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_code = 1;
      step();
    end
    in_valid = 0;
    in_code = 0;
    rst = 1;
    step();
    check_zero("mid_rst");
    rst = 0;
    exp_q.delete();
    got_q.delete();
    send_frame(32'h5A, 8, 0, 0);
    step();
    drain("after_rst");

    rnd = 1;
    for (int f = 0; f < 25; f++) begin
      send_frame($urandom, $urandom_range(1, 32), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(1, 3)) step();
    end
    drain("random");
    check("random_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
